// File: rtl/rvfi_mem_model.sv
// rvfi_mem_model: word-addressed instruction/data memory model for RVFI-style benches.
// Read: rd_valid/rd_ready request, rvalid/rdata response after LATENCY cycles, in order.
// Write (WRITABLE=1): byte-strobed, no response; out-of-window reads flagged on rd_oob.
//
// Ports:
//   clock, reset          - single clock, synchronous active-high reset
//   init_data             - initial image, word i at [i*XLEN +: XLEN]
//   stall                 - inhibits request acceptance when STALL_EN=1
//   rd_valid/rd_addr      - read request (byte address), rd_ready acceptance
//   rvalid/rdata          - read response
//   wr_en/wr_addr/wr_data/wr_strb - byte-lane write
//   rd_oob                - accepted read address lies above the modelled window
//   outstanding           - accepted reads whose response has not yet been presented
module rvfi_mem_model #(
  parameter int              XLEN        = 32,
  parameter int              WORDS       = 32,
  parameter int              LATENCY     = 1,
  parameter int              WRITABLE    = 0,
  parameter int              STALL_EN    = 0,
  parameter logic [XLEN-1:0] RESET_RDATA = 32'h00000013
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WORDS*XLEN-1:0]   init_data,
  input  logic                    stall,
  input  logic                    rd_valid,
  input  logic [XLEN-1:0]         rd_addr,
  output logic                    rd_ready,
  output logic                    rvalid,
  output logic [XLEN-1:0]         rdata,
  input  logic                    wr_en,
  input  logic [XLEN-1:0]         wr_addr,
  input  logic [XLEN-1:0]         wr_data,
  input  logic [XLEN/8-1:0]       wr_strb,
  output logic                    rd_oob,
  output logic [3:0]              outstanding
);

  localparam int IDX   = $clog2(WORDS);
  localparam int LANES = XLEN / 8;

  logic            accept;
  logic [IDX-1:0]  rd_idx;
  logic [IDX-1:0]  wr_idx;
  logic [XLEN-1:0] rd_word;

  assign rd_ready = !((STALL_EN != 0) && stall);
  // Requests presented during the reset cycle are dropped, not queued.
  assign accept   = rd_valid && rd_ready && !reset;

  // Address bits above the window alias back onto it; rd_oob reports that.
  assign rd_idx = rd_addr[IDX+1:2];
  assign wr_idx = wr_addr[IDX+1:2];
  assign rd_oob = accept && (rd_addr[XLEN-1:IDX+2] != '0);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[1:0], wr_addr[1:0], wr_addr[XLEN-1:IDX+2]};

  generate
    if (WRITABLE != 0) begin : g_ram
      logic [XLEN-1:0] mem [WORDS];

      // Read is taken from the pre-edge array, so a same-cycle write is not
      // visible to a read accepted in that cycle.
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < WORDS; i++) begin
            mem[i] <= init_data[i*XLEN +: XLEN];
          end
        end else if (wr_en) begin
          for (int b = 0; b < LANES; b++) begin
            if (wr_strb[b]) begin
              mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
          end
        end
      end

      assign rd_word = mem[rd_idx];
    end else begin : g_rom
      logic unused_wr;
      assign unused_wr = ^{wr_en, wr_data, wr_strb};
      assign rd_word   = init_data[rd_idx*XLEN +: XLEN];
    end
  endgenerate

  generate
    if (LATENCY == 0) begin : g_comb
      assign rvalid      = accept;
      assign rdata       = accept ? rd_word : '0;
      assign outstanding = '0;
    end else begin : g_pipe
      logic [LATENCY-1:0] vld_q;
      logic [XLEN-1:0]    dat_q [LATENCY];
      logic [XLEN-1:0]    last_q;
      logic [3:0]         cnt_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          vld_q  <= '0;
          last_q <= RESET_RDATA;
          cnt_q  <= '0;
        end else begin
          vld_q[0] <= accept;
          for (int s = 1; s < LATENCY; s++) begin
            vld_q[s] <= vld_q[s-1];
          end
          if (vld_q[LATENCY-1]) begin
            last_q <= dat_q[LATENCY-1];
          end
          // Count stays put when one read enters as another returns.
          case ({accept, vld_q[LATENCY-1]})
            2'b10:   cnt_q <= cnt_q + 4'd1;
            2'b01:   cnt_q <= cnt_q - 4'd1;
            default: cnt_q <= cnt_q;
          endcase
        end
      end

      // Data stages carry no reset; the valid bits qualify them.
      always_ff @(posedge clock) begin
        if (accept) begin
          dat_q[0] <= rd_word;
        end
        for (int s = 1; s < LATENCY; s++) begin
          dat_q[s] <= dat_q[s-1];
        end
      end

      // Outputs are forced to their reset values for the whole reset cycle,
      // not only after the reset edge.
      assign rvalid      = vld_q[LATENCY-1] && !reset;
      assign rdata       = reset ? RESET_RDATA :
                           (vld_q[LATENCY-1] ? dat_q[LATENCY-1] : last_q);
      assign outstanding = reset ? 4'd0 : cnt_q;
    end
  endgenerate

endmodule

// File: tb/tb_rvfi_mem_model.sv
module tb_rvfi_mem_model;

  logic          clock;
  logic          reset;
  logic [1023:0] init_data;
  logic          stall;
  logic          rd_valid;
  logic [31:0]   rd_addr;
  logic          wr_en;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;

  // a: LATENCY=1 writable, stallable; b: LATENCY=3; c: LATENCY=2; d: LATENCY=0
  logic a_rd_ready, a_rvalid, a_rd_oob; logic [31:0] a_rdata; logic [3:0] a_outstanding;
  logic b_rd_ready, b_rvalid, b_rd_oob; logic [31:0] b_rdata; logic [3:0] b_outstanding;
  logic c_rd_ready, c_rvalid, c_rd_oob; logic [31:0] c_rdata; logic [3:0] c_outstanding;
  logic d_rd_ready, d_rvalid, d_rd_oob; logic [31:0] d_rdata; logic [3:0] d_outstanding;

  int n_checks = 0;
  int n_fail   = 0;

  rvfi_mem_model #(.LATENCY(1), .WRITABLE(1), .STALL_EN(1)) dut_a (
    .clock(clock), .reset(reset), .init_data(init_data), .stall(stall),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(a_rd_ready), .rvalid(a_rvalid),
    .rdata(a_rdata), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_oob(a_rd_oob), .outstanding(a_outstanding));

  rvfi_mem_model #(.LATENCY(3)) dut_b (
    .clock(clock), .reset(reset), .init_data(init_data), .stall(stall),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(b_rd_ready), .rvalid(b_rvalid),
    .rdata(b_rdata), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_oob(b_rd_oob), .outstanding(b_outstanding));

  rvfi_mem_model #(.LATENCY(2)) dut_c (
    .clock(clock), .reset(reset), .init_data(init_data), .stall(stall),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(c_rd_ready), .rvalid(c_rvalid),
    .rdata(c_rdata), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_oob(c_rd_oob), .outstanding(c_outstanding));

  rvfi_mem_model #(.LATENCY(0)) dut_d (
    .clock(clock), .reset(reset), .init_data(init_data), .stall(stall),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(d_rd_ready), .rvalid(d_rvalid),
    .rdata(d_rdata), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_oob(d_rd_oob), .outstanding(d_outstanding));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Image: word 2 = 0, word 3 = DEADBEEF, every other word = A0000000 | index.
  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h0;
    if (i == 3) return 32'hDEADBEEF;
    return 32'hA0000000 | 32'(i);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      rd_valid = 1'b0; wr_en = 1'b0; stall = 1'b0;
    end
  endtask

  task automatic test_reset();
    tick(); tick(); #1;
    n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_a_rvalid got=%0h exp=0", a_rvalid); end
    n_checks++; if (a_rdata !== 32'h13) begin n_fail++; $display("FAIL rst_a_rdata got=%h exp=00000013", a_rdata); end
    n_checks++; if (a_outstanding !== 4'd0) begin n_fail++; $display("FAIL rst_a_outstanding got=%0d exp=0", a_outstanding); end
    n_checks++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_b_rvalid got=%0h exp=0", b_rvalid); end
    n_checks++; if (c_rdata !== 32'h13) begin n_fail++; $display("FAIL rst_c_rdata got=%h exp=00000013", c_rdata); end
    n_checks++; if (d_outstanding !== 4'd0) begin n_fail++; $display("FAIL rst_d_outstanding got=%0d exp=0", d_outstanding); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_latency1();
    tick(); rd_valid = 1'b1; rd_addr = 32'h0C; #1;
    n_checks++; if (a_rd_ready !== 1'b1) begin n_fail++; $display("FAIL l1_ready got=%0h exp=1", a_rd_ready); end
    n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL l1_early_rvalid got=%0h exp=0", a_rvalid); end
    n_checks++; if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL l0_rvalid got=%0h exp=1", d_rvalid); end
    n_checks++; if (d_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL l0_rdata got=%h exp=deadbeef", d_rdata); end
    n_checks++; if (a_rd_oob !== 1'b0) begin n_fail++; $display("FAIL l1_oob got=%0h exp=0", a_rd_oob); end
    tick(); rd_valid = 1'b0; #1;
    n_checks++; if (a_rvalid !== 1'b1) begin n_fail++; $display("FAIL l1_rvalid got=%0h exp=1", a_rvalid); end
    n_checks++; if (a_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL l1_rdata got=%h exp=deadbeef", a_rdata); end
    n_checks++; if (a_outstanding !== 4'd1) begin n_fail++; $display("FAIL l1_outstanding got=%0d exp=1", a_outstanding); end
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL l0_idle_rvalid got=%0h exp=0", d_rvalid); end
    n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL l0_idle_rdata got=%h exp=00000000", d_rdata); end
    tick(); #1;
    n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL l1_single_rvalid got=%0h exp=0", a_rvalid); end
    n_checks++; if (a_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL l1_hold_rdata got=%h exp=deadbeef", a_rdata); end
    n_checks++; if (a_outstanding !== 4'd0) begin n_fail++; $display("FAIL l1_drained got=%0d exp=0", a_outstanding); end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 7; t++) begin
      logic       exp_v;
      logic [3:0] exp_o;
      tick();
      rd_valid = (t < 3);
      rd_addr  = 32'(t * 4);
      #1;
      exp_v = (t >= 3) && (t <= 5);
      exp_o = (t <= 3) ? 4'(t) : 4'(6 - t);
      n_checks++; if (b_rvalid !== exp_v) begin n_fail++; $display("FAIL b2b_rvalid t=%0d got=%0h exp=%0h", t, b_rvalid, exp_v); end
      n_checks++; if (b_outstanding !== exp_o) begin n_fail++; $display("FAIL b2b_outstanding t=%0d got=%0d exp=%0d", t, b_outstanding, exp_o); end
      if (exp_v) begin
        n_checks++; if (b_rdata !== init_word(t - 3)) begin n_fail++; $display("FAIL b2b_rdata t=%0d got=%h exp=%h", t, b_rdata, init_word(t - 3)); end
      end
    end
  endtask

  task automatic test_oob();
    tick(); rd_valid = 1'b0; rd_addr = 32'h80; #1;
    n_checks++; if (a_rd_oob !== 1'b0) begin n_fail++; $display("FAIL oob_noaccept got=%0h exp=0", a_rd_oob); end
    tick(); rd_valid = 1'b1; rd_addr = 32'h80; #1;
    n_checks++; if (a_rd_oob !== 1'b1) begin n_fail++; $display("FAIL oob_80 got=%0h exp=1", a_rd_oob); end
    tick(); rd_addr = 32'h7C; #1;
    n_checks++; if (a_rd_oob !== 1'b0) begin n_fail++; $display("FAIL oob_7c got=%0h exp=0", a_rd_oob); end
    n_checks++; if (a_rdata !== init_word(0)) begin n_fail++; $display("FAIL oob_wrap_rdata got=%h exp=%h", a_rdata, init_word(0)); end
    tick(); rd_valid = 1'b0; #1;
    n_checks++; if (a_rdata !== init_word(31)) begin n_fail++; $display("FAIL oob_last_rdata got=%h exp=%h", a_rdata, init_word(31)); end
  endtask

  task automatic test_write();
    tick();
    wr_en = 1'b1; wr_addr = 32'h08; wr_data = 32'h11223344; wr_strb = 4'b0101;
    rd_valid = 1'b1; rd_addr = 32'h08; #1;
    tick(); wr_en = 1'b0; #1;
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_same_cycle got=%h exp=00000000", a_rdata); end
    n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rom_unchanged got=%h exp=00000000", d_rdata); end
    tick(); rd_valid = 1'b0; #1;
    n_checks++; if (a_rvalid !== 1'b1) begin n_fail++; $display("FAIL wr_next_rvalid got=%0h exp=1", a_rvalid); end
    n_checks++; if (a_rdata !== 32'h00220044) begin n_fail++; $display("FAIL wr_next_rdata got=%h exp=00220044", a_rdata); end
  endtask

  task automatic test_stall();
    for (int t = 0; t < 2; t++) begin
      tick(); stall = 1'b1; rd_valid = 1'b1; rd_addr = 32'h04; #1;
      n_checks++; if (a_rd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready t=%0d got=%0h exp=0", t, a_rd_ready); end
      n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL stall_rvalid t=%0d got=%0h exp=0", t, a_rvalid); end
      n_checks++; if (d_rd_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ignored t=%0d got=%0h exp=1", t, d_rd_ready); end
    end
    tick(); stall = 1'b0; #1;
    n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL stall_release_rvalid got=%0h exp=0", a_rvalid); end
    tick(); rd_valid = 1'b0; #1;
    n_checks++; if (a_rvalid !== 1'b1) begin n_fail++; $display("FAIL stall_resp_rvalid got=%0h exp=1", a_rvalid); end
    n_checks++; if (a_rdata !== init_word(1)) begin n_fail++; $display("FAIL stall_resp_rdata got=%h exp=%h", a_rdata, init_word(1)); end
    tick(); #1;
    n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL stall_single got=%0h exp=0", a_rvalid); end
  endtask

  task automatic test_reset_flush();
    tick(); rd_valid = 1'b1; rd_addr = 32'h0C; #1;
    tick();
    reset = 1'b1; rd_addr = 32'h08;
    wr_en = 1'b1; wr_addr = 32'h08; wr_data = 32'hFFFFFFFF; wr_strb = 4'hF; #1;
    n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL flush_rst_rvalid got=%0h exp=0", c_rvalid); end
    n_checks++; if (c_rdata !== 32'h13) begin n_fail++; $display("FAIL flush_rst_rdata got=%h exp=00000013", c_rdata); end
    n_checks++; if (c_outstanding !== 4'd0) begin n_fail++; $display("FAIL flush_rst_outstanding got=%0d exp=0", c_outstanding); end
    tick(); reset = 1'b0; wr_en = 1'b0; rd_valid = 1'b1; rd_addr = 32'h08; #1;
    n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL flush_rvalid got=%0h exp=0", c_rvalid); end
    n_checks++; if (c_rdata !== 32'h13) begin n_fail++; $display("FAIL flush_rdata got=%h exp=00000013", c_rdata); end
    n_checks++; if (c_outstanding !== 4'd0) begin n_fail++; $display("FAIL flush_outstanding got=%0d exp=0", c_outstanding); end
    n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL flush_rst_read_ignored got=%0h exp=0", a_rvalid); end
    tick(); rd_valid = 1'b0; #1;
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL flush_reload got=%h exp=00000000", a_rdata); end
    n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL flush_no_late_rvalid got=%0h exp=0", c_rvalid); end
    n_checks++; if (c_outstanding !== 4'd1) begin n_fail++; $display("FAIL flush_new_outstanding got=%0d exp=1", c_outstanding); end
    tick(); #1;
    n_checks++; if (c_rvalid !== 1'b1) begin n_fail++; $display("FAIL flush_new_rvalid got=%0h exp=1", c_rvalid); end
    n_checks++; if (c_rdata !== 32'h0) begin n_fail++; $display("FAIL flush_new_rdata got=%h exp=00000000", c_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) init_data[i*32 +: 32] = init_word(i);
    reset = 1'b1; stall = 1'b0; rd_valid = 1'b0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    test_reset();
    test_latency1();
    idle(4);
    test_back_to_back();
    idle(4);
    test_oob();
    idle(4);
    test_write();
    idle(4);
    test_stall();
    idle(4);
    test_reset_flush();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
